// File: rtl/hazard_controller_if.sv
// Hazard controller bus: decode-stage metadata and E/M status in from the
// core, stage stall/flush controls, forward selects and perf counters out.
interface hazard_controller_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic                  validD;
    logic [REG_ADDR_W-1:0] rs1D;
    logic [REG_ADDR_W-1:0] rs2D;
    logic                  usesRs1D;
    logic                  usesRs2D;
    logic [REG_ADDR_W-1:0] rdD;
    logic                  regWriteD;
    logic                  memOpD;
    logic                  loadD;
    logic [1:0]            pcSrcE;
    logic                  dmemReady;

    logic                  stallF;
    logic                  stallD;
    logic                  stallE;
    logic                  stallM;
    logic                  flushD;
    logic                  flushE;
    logic                  flushW;
    logic [1:0]            rs1ForwardSrcE;
    logic [1:0]            rs2ForwardSrcE;
    logic [CNT_W-1:0]      loadUseStallCnt;
    logic [CNT_W-1:0]      memStallCnt;
    logic [CNT_W-1:0]      flushCnt;

    // Core side
    modport master (
        output validD, rs1D, rs2D, usesRs1D, usesRs2D, rdD, regWriteD,
               memOpD, loadD, pcSrcE, dmemReady,
        input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               rs1ForwardSrcE, rs2ForwardSrcE,
               loadUseStallCnt, memStallCnt, flushCnt
    );

    // Hazard controller side
    modport slave (
        input  validD, rs1D, rs2D, usesRs1D, usesRs2D, rdD, regWriteD,
               memOpD, loadD, pcSrcE, dmemReady,
        output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
               rs1ForwardSrcE, rs2ForwardSrcE,
               loadUseStallCnt, memStallCnt, flushCnt
    );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencer for the 5-stage core. Tracks register-usage metadata
// for E/M/W/PostW and derives stalls, flushes, E-stage forward selects and
// stall/flush performance counters.
module hazard_controller #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    hazard_controller_if.slave bus
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regWrite;
        logic                  memOp;
        logic                  load;
    } stage_t;

    typedef struct packed {
        stage_t                s;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  usesRs1;
        logic                  usesRs2;
    } ex_t;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_M     = 2'd1,
        FWD_W     = 2'd2,
        FWD_POSTW = 2'd3
    } fwd_e;

    ex_t    e_q, e_d;
    stage_t m_q, m_d;
    stage_t w_q, w_d;
    stage_t pw_q, pw_d;

    logic [CNT_W-1:0] lu_cnt_q, ms_cnt_q, fl_cnt_q;

    logic mem_stall, redirect, load_use;
    fwd_e fwd1, fwd2;

    function automatic fwd_e fwd_sel(
        input logic                  uses,
        input logic [REG_ADDR_W-1:0] src,
        input ex_t                   e,
        input stage_t                m,
        input stage_t                w,
        input stage_t                pw
    );
        fwd_e sel;
        sel = FWD_NONE;
        if (e.s.valid && uses && (src != '0)) begin
            // A load in M cannot supply its data yet, so it never wins here
            if (m.valid && m.regWrite && !m.load && (m.rd == src))
                sel = FWD_M;
            else if (w.valid && w.regWrite && (w.rd == src))
                sel = FWD_W;
            else if (pw.valid && pw.regWrite && (pw.rd == src))
                sel = FWD_POSTW;
        end
        return sel;
    endfunction

    // Hazard conditions, in priority order memStall > redirect > loadUse
    always_comb begin
        mem_stall = m_q.valid && m_q.memOp && !bus.dmemReady;
        redirect  = e_q.s.valid && (bus.pcSrcE != 2'd0) && !mem_stall;
        load_use  = !mem_stall && !redirect && bus.validD && e_q.s.valid &&
                    e_q.s.load && e_q.s.regWrite && (e_q.s.rd != '0) &&
                    ((bus.usesRs1D && (bus.rs1D == e_q.s.rd)) ||
                     (bus.usesRs2D && (bus.rs2D == e_q.s.rd)));
        fwd1      = fwd_sel(e_q.usesRs1, e_q.rs1, e_q, m_q, w_q, pw_q);
        fwd2      = fwd_sel(e_q.usesRs2, e_q.rs2, e_q, m_q, w_q, pw_q);
    end

    // Shadow pipeline next state
    always_comb begin
        e_d  = e_q;
        m_d  = m_q;
        w_d  = w_q;
        pw_d = w_q;
        if (mem_stall) begin
            // E and M freeze; the W slot is filled with a bubble
            w_d = '0;
        end else begin
            w_d = m_q;
            m_d = e_q.s;
            e_d = '0;
            if (!redirect && !load_use && bus.validD) begin
                e_d.s.valid    = 1'b1;
                e_d.s.rd       = bus.rdD;
                e_d.s.regWrite = bus.regWriteD;
                e_d.s.memOp    = bus.memOpD;
                e_d.s.load     = bus.loadD;
                e_d.rs1        = bus.rs1D;
                e_d.rs2        = bus.rs2D;
                e_d.usesRs1    = bus.usesRs1D;
                e_d.usesRs2    = bus.usesRs2D;
            end
        end
    end

    // Shadow pipeline and performance counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q      <= '0;
            m_q      <= '0;
            w_q      <= '0;
            pw_q     <= '0;
            lu_cnt_q <= '0;
            ms_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            e_q  <= e_d;
            m_q  <= m_d;
            w_q  <= w_d;
            pw_q <= pw_d;
            if (load_use)  lu_cnt_q <= lu_cnt_q + CNT_W'(1);
            if (mem_stall) ms_cnt_q <= ms_cnt_q + CNT_W'(1);
            if (redirect)  fl_cnt_q <= fl_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stallF          = mem_stall | load_use;
    assign bus.stallD          = mem_stall | load_use;
    assign bus.stallE          = mem_stall;
    assign bus.stallM          = mem_stall;
    assign bus.flushD          = redirect;
    assign bus.flushE          = redirect | load_use;
    assign bus.flushW          = mem_stall;
    assign bus.rs1ForwardSrcE  = fwd1;
    assign bus.rs2ForwardSrcE  = fwd2;
    assign bus.loadUseStallCnt = lu_cnt_q;
    assign bus.memStallCnt     = ms_cnt_q;
    assign bus.flushCnt        = fl_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed vector bench for hazard_controller: a table of per-cycle decode
// inputs with hand-computed controls/forward selects, plus a hand-written
// async-reset-during-stall sequence.
module tb_hazard_controller;

    localparam int RW = 5;
    localparam int CW = 32;

    // {stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    localparam logic [6:0] C0  = 7'b0000000;
    localparam logic [6:0] CLU = 7'b1100010;
    localparam logic [6:0] CMS = 7'b1111001;
    localparam logic [6:0] CRD = 7'b0000110;

    typedef struct {
        logic          vD;
        logic [RW-1:0] rs1;
        logic [RW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mo;
        logic          ld;
        logic [1:0]    pc;
        logic          rdy;
        logic [6:0]    ctl;
        logic [1:0]    f1;
        logic [1:0]    f2;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t tv[$];

    hazard_controller_if #(.REG_ADDR_W(RW), .CNT_W(CW)) bus ();

    hazard_controller #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic vD, input int rs1, input int rs2, input logic u1,
        input logic u2, input int rd, input logic rw, input logic mo,
        input logic ld, input int pc, input logic rdy, input logic [6:0] ctl,
        input int f1, input int f2
    );
        vec_t v;
        v.vD = vD;  v.rs1 = RW'(rs1); v.rs2 = RW'(rs2);
        v.u1 = u1;  v.u2 = u2;        v.rd = RW'(rd);
        v.rw = rw;  v.mo = mo;        v.ld = ld;
        v.pc = 2'(pc); v.rdy = rdy;   v.ctl = ctl;
        v.f1 = 2'(f1); v.f2 = 2'(f2);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.validD    = v.vD;
        bus.rs1D      = v.rs1;
        bus.rs2D      = v.rs2;
        bus.usesRs1D  = v.u1;
        bus.usesRs2D  = v.u2;
        bus.rdD       = v.rd;
        bus.regWriteD = v.rw;
        bus.memOpD    = v.mo;
        bus.loadD     = v.ld;
        bus.pcSrcE    = v.pc;
        bus.dmemReady = v.rdy;
    endtask

    function automatic logic [6:0] ctl_now();
        return {bus.stallF, bus.stallD, bus.stallE, bus.stallM,
                bus.flushD, bus.flushE, bus.flushW};
    endfunction

    initial begin
        vec_t nop;
        checks = 0;
        errors = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C0, 0, 0);
        drive(nop);

        // Back-to-back, distance 1 and distance 2 dependences
        tv.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 1, C0, 0, 0)); // add x5
        tv.push_back(mk(1,  5,  3, 1, 1,  6, 1, 0, 0, 0, 1, C0, 0, 0)); // sub x6,x5
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0, 1, 0)); // E=sub M=add
        tv.push_back(mk(1,  1,  2, 1, 1,  8, 1, 0, 0, 0, 1, C0, 0, 0)); // add x8
        tv.push_back(mk(1, 10, 11, 1, 1,  9, 1, 0, 0, 0, 1, C0, 0, 0)); // unrelated
        tv.push_back(mk(1, 13,  8, 1, 1, 12, 1, 0, 0, 0, 1, C0, 0, 0)); // reads x8
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0, 0, 2)); // W has x8
        tv.push_back(mk(1,  1,  2, 1, 1, 14, 1, 0, 0, 0, 1, C0, 0, 0)); // add x14
        tv.push_back(mk(1, 16, 17, 1, 1, 15, 1, 0, 0, 0, 1, C0, 0, 0)); // unrelated
        tv.push_back(mk(1, 19, 20, 1, 1, 18, 1, 0, 0, 0, 1, C0, 0, 0)); // unrelated
        tv.push_back(mk(1, 22, 14, 1, 1, 21, 1, 0, 0, 0, 1, C0, 0, 0)); // reads x14
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0, 0, 3)); // PostW x14
        // Load-use
        tv.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 1, 0, 1, C0,  0, 0)); // lw x7
        tv.push_back(mk(1,  4,  7, 1, 1,  3, 1, 0, 0, 0, 1, CLU, 0, 0)); // uses x7
        tv.push_back(mk(1,  4,  7, 1, 1,  3, 1, 0, 0, 0, 1, C0,  0, 0)); // held D
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0,  0, 2)); // W has lw
        // x0 destinations
        tv.push_back(mk(1,  1,  0, 1, 0,  0, 1, 1, 1, 0, 1, C0, 0, 0)); // lw x0
        tv.push_back(mk(1,  0,  0, 1, 1,  0, 1, 0, 0, 0, 1, C0, 0, 0)); // add x0,x0
        tv.push_back(mk(1,  0,  5, 1, 1,  4, 1, 0, 0, 0, 1, C0, 0, 0)); // reads x0
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0, 0, 0)); // M=add x0
        // Memory wait: store in M, ready low for 3 cycles
        tv.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 1, C0,  0, 0)); // add x5
        tv.push_back(mk(1,  5,  6, 1, 1,  0, 0, 1, 0, 0, 1, C0,  0, 0)); // sw
        tv.push_back(mk(1, 12, 13, 1, 1, 10, 1, 0, 0, 0, 1, C0,  1, 0)); // add x10
        tv.push_back(mk(1, 10,  5, 1, 1, 11, 1, 0, 0, 0, 0, CMS, 0, 0)); // wait 1
        tv.push_back(mk(1, 10,  5, 1, 1, 11, 1, 0, 0, 0, 0, CMS, 0, 0)); // wait 2
        tv.push_back(mk(1, 10,  5, 1, 1, 11, 1, 0, 0, 0, 0, CMS, 0, 0)); // wait 3
        tv.push_back(mk(1, 10,  5, 1, 1, 11, 1, 0, 0, 0, 1, C0,  0, 0)); // release
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0,  1, 0)); // x10 in M
        // Redirect deferred by memStall
        tv.push_back(mk(1,  1,  0, 1, 0, 20, 1, 1, 1, 0, 1, C0,  0, 0)); // lw x20
        tv.push_back(mk(1,  2,  3, 1, 1,  0, 0, 0, 0, 0, 1, C0,  0, 0)); // beq
        tv.push_back(mk(1,  4,  4, 1, 1, 22, 1, 0, 0, 2, 0, CMS, 0, 0)); // stall
        tv.push_back(mk(1,  4,  4, 1, 1, 22, 1, 0, 0, 2, 0, CMS, 0, 0)); // stall
        tv.push_back(mk(1,  4,  4, 1, 1, 22, 1, 0, 0, 2, 1, CRD, 0, 0)); // redirect
        tv.push_back(mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1, C0,  0, 0)); // bubble

        // Reset state
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_ctl", 32'(ctl_now()), 32'(C0));
        check("reset_fwd", {28'd0, bus.rs1ForwardSrcE, bus.rs2ForwardSrcE}, 32'd0);
        check("reset_lucnt", bus.loadUseStallCnt, 32'd0);
        check("reset_mscnt", bus.memStallCnt, 32'd0);
        check("reset_flcnt", bus.flushCnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i]);
            #1;
            check($sformatf("v%0d_ctl", i), 32'(ctl_now()), 32'(tv[i].ctl));
            check($sformatf("v%0d_fwd1", i), 32'(bus.rs1ForwardSrcE), 32'(tv[i].f1));
            check($sformatf("v%0d_fwd2", i), 32'(bus.rs2ForwardSrcE), 32'(tv[i].f2));
        end
        @(negedge clk);
        drive(nop);
        #1;
        check("tbl_lucnt", bus.loadUseStallCnt, 32'd1);
        check("tbl_mscnt", bus.memStallCnt, 32'd5);
        check("tbl_flcnt", bus.flushCnt, 32'd1);

        // Async reset in the middle of a memory stall
        drive(mk(1, 1, 2, 1, 1, 9, 1, 0, 0, 0, 1, C0, 0, 0));   // add x9
        @(negedge clk);
        drive(mk(1, 3, 4, 1, 1, 0, 0, 1, 0, 0, 1, C0, 0, 0));   // sw
        @(negedge clk);
        drive(mk(1, 9, 3, 1, 1, 10, 1, 0, 0, 0, 1, C0, 0, 0));  // reads x9
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C0, 0, 0));   // sw waits
        #1;
        check("pre_rst_ctl", 32'(ctl_now()), 32'(CMS));
        check("pre_rst_fwd1", 32'(bus.rs1ForwardSrcE), 32'd2);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_ctl", 32'(ctl_now()), 32'(C0));
        check("mid_rst_fwd", {28'd0, bus.rs1ForwardSrcE, bus.rs2ForwardSrcE}, 32'd0);
        check("mid_rst_mscnt", bus.memStallCnt, 32'd0);
        check("mid_rst_lucnt", bus.loadUseStallCnt, 32'd0);
        check("mid_rst_flcnt", bus.flushCnt, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1, 1, 2, 1, 1, 7, 1, 0, 0, 0, 1, C0, 0, 0));   // add x7
        #1;
        check("post_rst_ctl", 32'(ctl_now()), 32'(C0));
        check("post_rst_fwd1", 32'(bus.rs1ForwardSrcE), 32'd0);
        @(negedge clk);
        drive(mk(1, 7, 8, 1, 1, 6, 1, 0, 0, 0, 1, C0, 0, 0));   // reads x7
        #1;
        check("post_rst_e_fwd1", 32'(bus.rs1ForwardSrcE), 32'd0);
        @(negedge clk);
        drive(nop);
        #1;
        check("post_rst_m_fwd1", 32'(bus.rs1ForwardSrcE), 32'd1);
        check("post_rst_mscnt", bus.memStallCnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
